// File: rtl/ep_cfg_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port among g_num_req agents.
// Optional hung-access timeout via EP_CFG_ARB_TIMEOUT_EN.
//
// Ports:
//   clk_sys_i, rst_n_i (async, active-high)
//   req_i/req_we_i/req_adr_i/req_dat_i/req_sel_i : packed per-requester access
//   gnt_o, done_o, err_o, rdata_o                : owner status and read data
//   wb_cyc/stb/we/adr/sel/dat_o                  : Wishbone master controls
//   wb_dat/ack/err/stall_i                       : Wishbone slave response
module ep_cfg_wb_arbiter #(
  parameter int g_num_req   = 6,
  parameter int g_adr_width = 8,
  parameter int g_timeout   = 255
) (
  input  logic                           clk_sys_i,
  input  logic                           rst_n_i,
  input  logic [g_num_req-1:0]           req_i,
  input  logic [g_num_req-1:0]           req_we_i,
  input  logic [g_num_req*g_adr_width-1:0] req_adr_i,
  input  logic [g_num_req*32-1:0]        req_dat_i,
  input  logic [g_num_req*4-1:0]         req_sel_i,
  output logic [g_num_req-1:0]           gnt_o,
  output logic [g_num_req-1:0]           done_o,
  output logic                           err_o,
  output logic [31:0]                    rdata_o,
  output logic                           wb_cyc_o,
  output logic                           wb_stb_o,
  output logic                           wb_we_o,
  output logic [g_adr_width-1:0]         wb_adr_o,
  output logic [3:0]                     wb_sel_o,
  output logic [31:0]                    wb_dat_o,
  input  logic [31:0]                    wb_dat_i,
  input  logic                           wb_ack_i,
  input  logic                           wb_err_i,
  input  logic                           wb_stall_i
);

  localparam int IW = (g_num_req > 1) ? $clog2(g_num_req) : 1;
  localparam int AW = g_adr_width;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, owner_q, pick;
  logic            found;
  logic            we_q, err_q;
  logic [AW-1:0]   adr_q;
  logic [31:0]     dat_q, rdata_q;
  logic [3:0]      sel_q;
  logic [g_num_req-1:0] own_oh;
  logic            resp, cap, tmo, tmo_hit;

  assign resp = wb_ack_i | wb_err_i;

  // First set request scanning upward from ptr, wrapping.
  always_comb begin
    int k;
    k     = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < g_num_req; i++) begin
      k = int'(ptr_q) + i;
      if (k >= g_num_req) k = k - g_num_req;
      if (!found && req_i[k]) begin
        found = 1'b1;
        pick  = IW'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    tmo_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) state_d = ISSUE;
      end
      ISSUE: begin
        if (!wb_stall_i && resp) begin
          cap     = 1'b1;
          state_d = DONE;
        end else if (tmo) begin
          tmo_hit = 1'b1;
          state_d = DONE;
        end else if (!wb_stall_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (resp) begin
          cap     = 1'b1;
          state_d = DONE;
        end else if (tmo) begin
          tmo_hit = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) begin
        owner_q <= pick;
        we_q    <= req_we_i[pick];
        adr_q   <= req_adr_i[pick*AW +: AW];
        dat_q   <= req_dat_i[pick*32 +: 32];
        sel_q   <= req_sel_i[pick*4 +: 4];
        err_q   <= 1'b0;
      end
      // ack together with err reports err
      if (cap) begin
        err_q <= wb_err_i;
        if (!we_q) rdata_q <= wb_dat_i;
      end
      if (tmo_hit) err_q <= 1'b1;
      if (state_q == DONE) begin
        ptr_q <= (owner_q == IW'(g_num_req-1)) ? '0 : owner_q + 1'b1;
      end
    end
  end

`ifdef EP_CFG_ARB_TIMEOUT_EN
  localparam int TW0 = $clog2(g_timeout+1);
  localparam int TW  = (TW0 > 8) ? TW0 : 8;
  logic [TW-1:0] cnt_q;

  // Cleared in IDLE so it starts at zero on ISSUE entry.
  always_ff @(posedge clk_sys_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE || state_q == WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tmo = (cnt_q == TW'(g_timeout-1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    own_oh          = '0;
    own_oh[owner_q] = 1'b1;
  end

  assign gnt_o    = (state_q != IDLE) ? own_oh : '0;
  assign done_o   = (state_q == DONE) ? own_oh : '0;
  assign err_o    = (state_q == DONE) & err_q;
  assign rdata_o  = rdata_q;
  assign wb_cyc_o = (state_q == ISSUE) || (state_q == WAIT);
  assign wb_stb_o = (state_q == ISSUE);
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;
  assign wb_dat_o = dat_q;

endmodule
